// File: rtl/pico_irq_scheduler.sv
// Round-robin scheduler that funnels N event sources onto the PicoBlaze interrupt line,
// with 1-deep holding slots per source and a registered in_port read mux.
module pico_irq_scheduler #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned TIMEOUT   = 4096,
    parameter logic [7:0]  BASE_PORT = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      src_strobe,
    input  logic [N_SRC*DW-1:0]   src_data,
    output logic                  interrupt,
    input  logic                  interrupt_ack,
    input  logic [7:0]            port_id,
    input  logic                  read_strobe,
    input  logic                  write_strobe,
    input  logic [7:0]            out_port,
    output logic [7:0]            in_port,
    output logic [N_SRC-1:0]      overflow
);

    localparam int unsigned ID_W  = $clog2(N_SRC);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [7:0] P_DATA    = BASE_PORT;
    localparam logic [7:0] P_SRC_ID  = BASE_PORT + 8'd1;
    localparam logic [7:0] P_PENDING = BASE_PORT + 8'd2;
    localparam logic [7:0] P_STATUS  = BASE_PORT + 8'd3;
    localparam logic [7:0] P_CLR     = BASE_PORT + 8'd4;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_ACK, SERVICE} state_t;

    state_t            state, state_next;
    logic [1:0]        rst_q;
    logic              rst_i;
    logic [N_SRC-1:0]  strobe_q;
    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  slot_full;
    logic [DW-1:0]     slot_data [N_SRC];
    logic [N_SRC-1:0]  granted;
    logic [ID_W-1:0]   rr;
    logic [ID_W-1:0]   cur_id;
    logic [DW-1:0]     cur_data;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_flag;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              data_rd;
    logic              retire;
    logic              timed_out;
    logic [N_SRC-1:0]  ovf_set;
    logic [N_SRC-1:0]  ovf_clr;
    logic              tf_clr;
    logic [7:0]        pend;
    logic [7:0]        rd_mux;
    logic              unused_bits;

    assign unused_bits = ^out_port;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int unsigned k);
        int unsigned s;
        s = 32'(a) + k;
        if (s >= N_SRC) s = s - N_SRC;
        return ID_W'(s);
    endfunction

    // Reset asserts asynchronously, releases on a clock edge two cycles later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_q <= 2'b11;
        else       rst_q <= {rst_q[0], 1'b0};
    end
    assign rst_i = rst_q[1];

    assign rise    = src_strobe & ~strobe_q;
    assign data_rd = read_strobe && (port_id == P_DATA);
    assign tf_clr  = write_strobe && (port_id == P_CLR) && out_port[7];
    assign ovf_clr = (write_strobe && (port_id == P_CLR)) ? out_port[N_SRC-1:0] : '0;
    assign ovf_set = rise & (slot_full | granted);

    always_comb begin
        granted = '0;
        if (state != IDLE) granted[cur_id] = 1'b1;
    end

    // First full slot at or after the round-robin pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!pick_found && slot_full[wrap_add(rr, k)]) begin
                pick_found = 1'b1;
                pick_id    = wrap_add(rr, k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE:     if (pick_found) state_next = GRANT;
            GRANT:    state_next = WAIT_ACK;
            WAIT_ACK: if (interrupt_ack) state_next = SERVICE;
            SERVICE: begin
                if (data_rd) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    retire     = 1'b1;
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        pend             = '0;
        pend[N_SRC-1:0]  = slot_full;
        rd_mux           = 8'h00;
        if      (port_id == P_DATA)    rd_mux = 8'(cur_data);
        else if (port_id == P_SRC_ID)  rd_mux = 8'(cur_id);
        else if (port_id == P_PENDING) rd_mux = pend;
        else if (port_id == P_STATUS)  rd_mux = {6'b0, state == SERVICE, timeout_flag};
    end

    // Slot capture, grant latching, retirement and processor-visible registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            strobe_q     <= '0;
            slot_full    <= '0;
            for (int i = 0; i < N_SRC; i++) slot_data[i] <= '0;
            rr           <= '0;
            cur_id       <= '0;
            cur_data     <= '0;
            cnt          <= '0;
            timeout_flag <= 1'b0;
            overflow     <= '0;
            interrupt    <= 1'b0;
            in_port      <= 8'h00;
        end else begin
            strobe_q <= src_strobe;
            for (int i = 0; i < N_SRC; i++) begin
                if (rise[i] && !granted[i]) begin
                    slot_data[i] <= src_data[i*DW +: DW];
                    slot_full[i] <= 1'b1;
                end
            end
            if (retire) begin
                slot_full[cur_id] <= 1'b0;
                rr                <= wrap_add(cur_id, 1);
            end
            if (state == IDLE && pick_found) begin
                cur_id   <= pick_id;
                cur_data <= slot_data[pick_id];
            end
            if (state == WAIT_ACK)     cnt <= '0;
            else if (state == SERVICE) cnt <= cnt + CNT_W'(1);
            if (timed_out)   timeout_flag <= 1'b1;
            else if (tf_clr) timeout_flag <= 1'b0;
            overflow  <= (overflow & ~ovf_clr) | ovf_set;
            interrupt <= (state_next == WAIT_ACK);
            in_port   <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pico_irq_scheduler.sv
// Directed self-checking bench for pico_irq_scheduler.
module tb_pico_irq_scheduler;

    localparam int unsigned N_SRC = 4;
    localparam int unsigned TMO   = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  src_strobe = '0;
    logic [31:0] src_data = '0;
    logic        interrupt;
    logic        interrupt_ack = 1'b0;
    logic [7:0]  port_id = 8'h10;
    logic        read_strobe = 1'b0;
    logic        write_strobe = 1'b0;
    logic [7:0]  out_port = 8'h00;
    logic [7:0]  in_port;
    logic [3:0]  overflow;

    int checks = 0;
    int passed = 0;

    pico_irq_scheduler #(.N_SRC(N_SRC), .DW(8), .TIMEOUT(TMO), .BASE_PORT(8'h00)) dut (
        .clk(clk), .reset(reset), .src_strobe(src_strobe), .src_data(src_data),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack), .port_id(port_id),
        .read_strobe(read_strobe), .write_strobe(write_strobe), .out_port(out_port),
        .in_port(in_port), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] mask, input logic [31:0] data);
        src_data   = data;
        src_strobe = mask;
        tick();
        src_strobe = '0;
        tick();
    endtask

    task automatic read_port(input logic [7:0] addr, output logic [7:0] v);
        port_id = addr;
        tick();
        v = in_port;
        port_id = 8'h10;
    endtask

    task automatic write_port(input logic [7:0] addr, input logic [7:0] v);
        port_id      = addr;
        out_port     = v;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id      = 8'h10;
    endtask

    task automatic wait_irq(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (interrupt) ok = 1'b1;
            else tick();
        end
    endtask

    // Wait for interrupt, acknowledge, read source id then data (which retires the slot).
    task automatic do_grant(output logic ok, output logic [7:0] id, output logic [7:0] data);
        id   = 8'hxx;
        data = 8'hxx;
        wait_irq(ok);
        if (!ok) return;
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        read_port(8'h01, id);
        port_id     = 8'h00;
        read_strobe = 1'b1;
        tick();
        data        = in_port;
        read_strobe = 1'b0;
        port_id     = 8'h10;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1;
        #1;
        checks++; if (interrupt !== 1'b0) $display("FAIL reset_irq: got %b want 0", interrupt); else passed++;
        checks++; if (in_port !== 8'h00) $display("FAIL reset_in_port: got %h want 00", in_port); else passed++;
        checks++; if (overflow !== 4'b0000) $display("FAIL reset_overflow: got %b want 0000", overflow); else passed++;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        read_port(8'h02, v);
        checks++; if (v !== 8'h00) $display("FAIL reset_pending: got %h want 00", v); else passed++;
        read_port(8'h03, v);
        checks++; if (v !== 8'h00) $display("FAIL reset_status: got %h want 00", v); else passed++;
    endtask

    task automatic test_single();
        logic [7:0] v;
        src_data   = 32'h00A5_0000;
        src_strobe = 4'b0100;
        tick();
        src_strobe = '0;
        checks++; if (interrupt !== 1'b0) $display("FAIL t1_lat1: got %b want 0", interrupt); else passed++;
        tick();
        checks++; if (interrupt !== 1'b0) $display("FAIL t1_lat2: got %b want 0", interrupt); else passed++;
        tick();
        checks++; if (interrupt !== 1'b1) $display("FAIL t1_lat3: got %b want 1", interrupt); else passed++;
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        checks++; if (interrupt !== 1'b0) $display("FAIL t1_ack_drop: got %b want 0", interrupt); else passed++;
        read_port(8'h03, v);
        checks++; if (v !== 8'h02) $display("FAIL t1_status_service: got %h want 02", v); else passed++;
        read_port(8'h01, v);
        checks++; if (v !== 8'h02) $display("FAIL t1_src_id: got %h want 02", v); else passed++;
        port_id     = 8'h00;
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        checks++; if (in_port !== 8'hA5) $display("FAIL t1_data: got %h want A5", in_port); else passed++;
        read_port(8'h02, v);
        checks++; if (v !== 8'h00) $display("FAIL t1_pending: got %h want 00", v); else passed++;
        repeat (3) tick();
        checks++; if (interrupt !== 1'b0) $display("FAIL t1_irq_quiet: got %b want 0", interrupt); else passed++;
    endtask

    task automatic test_round_robin();
        logic ok;
        logic [7:0] id, d, v;
        logic [7:0] exp_id [5] = '{8'h00, 8'h01, 8'h03, 8'h00, 8'h03};
        logic [7:0] exp_d  [5] = '{8'h10, 8'h11, 8'h13, 8'h20, 8'h23};
        apply_reset();
        pulse(4'b1011, 32'h1312_1110);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) pulse(4'b1001, 32'h2300_0020);
            do_grant(ok, id, d);
            checks++; if (ok !== 1'b1) $display("FAIL t2_irq_%0d: no interrupt", i); else passed++;
            checks++; if (id !== exp_id[i]) $display("FAIL t2_id_%0d: got %h want %h", i, id, exp_id[i]); else passed++;
            checks++; if (d !== exp_d[i]) $display("FAIL t2_data_%0d: got %h want %h", i, d, exp_d[i]); else passed++;
        end
        read_port(8'h02, v);
        checks++; if (v !== 8'h00) $display("FAIL t2_pending: got %h want 00", v); else passed++;
    endtask

    task automatic test_overflow();
        logic ok;
        logic [7:0] id, d;
        apply_reset();
        pulse(4'b0001, 32'h0000_0050);
        pulse(4'b0010, 32'h0000_1100);
        pulse(4'b0010, 32'h0000_2200);
        checks++; if (overflow !== 4'b0010) $display("FAIL t3_ovf_set: got %b want 0010", overflow); else passed++;
        do_grant(ok, id, d);
        checks++; if (id !== 8'h00 || d !== 8'h50) $display("FAIL t3_first: got %h/%h want 00/50", id, d); else passed++;
        do_grant(ok, id, d);
        checks++; if (id !== 8'h01 || d !== 8'h22) $display("FAIL t3_second: got %h/%h want 01/22", id, d); else passed++;
        write_port(8'h04, 8'h02);
        checks++; if (overflow !== 4'b0000) $display("FAIL t3_ovf_clr: got %b want 0000", overflow); else passed++;
    endtask

    task automatic test_timeout();
        logic ok;
        logic [7:0] id, d, v;
        apply_reset();
        pulse(4'b0001, 32'h0000_0040);
        pulse(4'b0100, 32'h0042_0000);
        wait_irq(ok);
        checks++; if (ok !== 1'b1) $display("FAIL t4_irq: no interrupt"); else passed++;
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        repeat (TMO - 1) tick();
        read_port(8'h03, v);
        checks++; if (v !== 8'h02) $display("FAIL t4_before_timeout: got %h want 02", v); else passed++;
        read_port(8'h03, v);
        checks++; if (v !== 8'h01) $display("FAIL t4_status_flag: got %h want 01", v); else passed++;
        read_port(8'h02, v);
        checks++; if (v !== 8'h04) $display("FAIL t4_pending: got %h want 04", v); else passed++;
        do_grant(ok, id, d);
        checks++; if (id !== 8'h02 || d !== 8'h42) $display("FAIL t4_next_grant: got %h/%h want 02/42", id, d); else passed++;
        read_port(8'h03, v);
        checks++; if (v !== 8'h01) $display("FAIL t4_flag_sticky: got %h want 01", v); else passed++;
        write_port(8'h04, 8'h80);
        read_port(8'h03, v);
        checks++; if (v !== 8'h00) $display("FAIL t4_flag_clr: got %h want 00", v); else passed++;
    endtask

    task automatic test_masked();
        logic ok;
        logic dropped;
        logic [7:0] id, d, v;
        apply_reset();
        pulse(4'b0010, 32'h0000_3100);
        wait_irq(ok);
        checks++; if (ok !== 1'b1) $display("FAIL t5_irq: no interrupt"); else passed++;
        dropped = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                src_data   = 32'h0000_9900;
                src_strobe = 4'b0010;
            end else begin
                src_strobe = '0;
            end
            tick();
            if (interrupt !== 1'b1) dropped = 1'b1;
        end
        checks++; if (dropped !== 1'b0) $display("FAIL t5_irq_held: interrupt dropped without ack"); else passed++;
        checks++; if (overflow !== 4'b0010) $display("FAIL t5_ovf: got %b want 0010", overflow); else passed++;
        read_port(8'h03, v);
        checks++; if (v !== 8'h00) $display("FAIL t5_status: got %h want 00", v); else passed++;
        do_grant(ok, id, d);
        checks++; if (id !== 8'h01 || d !== 8'h31) $display("FAIL t5_data: got %h/%h want 01/31", id, d); else passed++;
        read_port(8'h02, v);
        checks++; if (v !== 8'h00) $display("FAIL t5_pending: got %h want 00", v); else passed++;
    endtask

    task automatic test_reset_mid_grant();
        logic ok;
        logic [7:0] id, d, v;
        apply_reset();
        pulse(4'b0010, 32'h0000_AA00);
        do_grant(ok, id, d);
        pulse(4'b1001, 32'h7700_0066);
        wait_irq(ok);
        read_port(8'h01, v);
        checks++; if (v !== 8'h03) $display("FAIL t6_pre_id: got %h want 03", v); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (interrupt !== 1'b0) $display("FAIL t6_irq: got %b want 0", interrupt); else passed++;
        checks++; if (in_port !== 8'h00) $display("FAIL t6_in_port: got %h want 00", in_port); else passed++;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        read_port(8'h02, v);
        checks++; if (v !== 8'h00) $display("FAIL t6_pending: got %h want 00", v); else passed++;
        pulse(4'b1010, 32'h3300_1100);
        do_grant(ok, id, d);
        checks++; if (id !== 8'h01 || d !== 8'h11) $display("FAIL t6_rr_reset: got %h/%h want 01/11", id, d); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_timeout();
        test_masked();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
